// File: rtl/chmu_pkg.sv
// Shared types and constants for the CHMU hot-list reader.
package chmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } hotlist_state_e;

  localparam int DROP_CNT_W = 16;

  // Saturating increment for the discarded-beat counter (no wrap at all-ones).
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == {DROP_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/chmu_hotlist_buf.sv
// Hot-list capture buffer: register array with one write port and a
// registered, count-masked read port for the CSR block.
module chmu_hotlist_buf #(
  parameter int ADDR_SIZE = 33,
  parameter int LIST_SIZE = 32,
  parameter int IDX_W     = $clog2(LIST_SIZE)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [ADDR_SIZE-1:0] wr_data,
  input  logic [IDX_W-1:0]     rd_idx,
  input  logic [IDX_W:0]       valid_cnt,
  output logic [ADDR_SIZE-1:0] rd_data
);

  // Contents are intentionally not reset; valid_cnt masks stale entries.
  logic [ADDR_SIZE-1:0] mem [LIST_SIZE];

  // Capture accepted stream beats.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; entries at or beyond the captured count read as zero,
  // so a same-cycle write to the indexed slot is not yet visible.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
    end else begin
      rd_data <= ({1'b0, rd_idx} < valid_cnt) ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/chmu_hotlist_reader.sv
// Host-side consumer of the CHMU tracker migration stream: issues a query,
// drains the returned entries into a buffer and exposes them over CSR reads.
module chmu_hotlist_reader
  import chmu_pkg::*;
#(
  parameter int ADDR_SIZE   = 33,
  parameter int LIST_SIZE   = 32,
  parameter int IDX_W       = $clog2(LIST_SIZE),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  csr_query_start,
  input  logic                  csr_clear,
  output logic                  query_en,
  input  logic                  query_ready,
  input  logic                  mig_addr_cnt_en,
  input  logic [ADDR_SIZE-1:0]  mig_addr_cnt,
  output logic                  mig_addr_cnt_ready,
  input  logic [IDX_W-1:0]      csr_rd_idx,
  output logic [ADDR_SIZE-1:0]  csr_rd_data,
  output logic [IDX_W:0]        csr_list_cnt,
  output logic                  csr_busy,
  output logic                  csr_done,
  output logic                  csr_timeout,
  output logic [DROP_CNT_W-1:0] csr_drop_cnt
);

  // Idle counter is sized so TIMEOUT_CYC==1 still yields a legal width.
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W:0]    CNT_LAST  = (IDX_W + 1)'(LIST_SIZE - 1);

  hotlist_state_e    state;
  logic [IDX_W-1:0]  wr_ptr;
  logic [IDLE_W-1:0] idle_cnt;
  logic              beat;
  logic              buf_wr_en;

  assign beat      = mig_addr_cnt_en & mig_addr_cnt_ready;
  assign buf_wr_en = beat & (state == ST_COLLECT);

  // Controller FSM; every CSR flag and handshake output is registered with the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= ST_IDLE;
      query_en           <= 1'b0;
      mig_addr_cnt_ready <= 1'b0;
      csr_list_cnt       <= '0;
      csr_busy           <= 1'b0;
      csr_done           <= 1'b0;
      csr_timeout        <= 1'b0;
      csr_drop_cnt       <= '0;
      wr_ptr             <= '0;
      idle_cnt           <= '0;
    end else begin
      case (state)
        // IDLE and DONE both swallow stray beats; clear beats start.
        ST_IDLE, ST_DONE: begin
          if (beat) begin
            csr_drop_cnt <= sat_inc(csr_drop_cnt);
          end
          if (csr_clear) begin
            state              <= ST_IDLE;
            mig_addr_cnt_ready <= 1'b1;
            csr_list_cnt       <= '0;
            csr_done           <= 1'b0;
            csr_timeout        <= 1'b0;
            csr_drop_cnt       <= '0;
          end else if (csr_query_start) begin
            state              <= ST_REQ;
            query_en           <= 1'b1;
            mig_addr_cnt_ready <= 1'b0;
            csr_busy           <= 1'b1;
            csr_done           <= 1'b0;
            csr_list_cnt       <= '0;
            csr_timeout        <= 1'b0;
            wr_ptr             <= '0;
            idle_cnt           <= '0;
          end else begin
            mig_addr_cnt_ready <= 1'b1;
          end
        end
        // Hold the query request until the tracker takes it.
        ST_REQ: begin
          if (query_ready) begin
            state              <= ST_COLLECT;
            query_en           <= 1'b0;
            mig_addr_cnt_ready <= 1'b1;
          end
        end
        // Drain entries until the list fills or the stream goes quiet.
        ST_COLLECT: begin
          if (beat) begin
            wr_ptr       <= wr_ptr + 1'b1;
            csr_list_cnt <= csr_list_cnt + 1'b1;
            idle_cnt     <= '0;
            if (csr_list_cnt == CNT_LAST) begin
              state       <= ST_DONE;
              csr_busy    <= 1'b0;
              csr_done    <= 1'b1;
              csr_timeout <= 1'b0;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            state       <= ST_DONE;
            csr_busy    <= 1'b0;
            csr_done    <= 1'b1;
            csr_timeout <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  chmu_hotlist_buf #(
    .ADDR_SIZE (ADDR_SIZE),
    .LIST_SIZE (LIST_SIZE),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (buf_wr_en),
    .wr_addr   (wr_ptr),
    .wr_data   (mig_addr_cnt),
    .rd_idx    (csr_rd_idx),
    .valid_cnt (csr_list_cnt),
    .rd_data   (csr_rd_data)
  );

endmodule

// File: tb/tb_chmu_hotlist_reader.sv
// Directed self-checking bench for chmu_hotlist_reader.
module tb_chmu_hotlist_reader;

  localparam int ADDR_SIZE   = 33;
  localparam int LIST_SIZE   = 32;
  localparam int IDX_W       = 5;
  localparam int TIMEOUT_CYC = 16;

  logic                 clk;
  logic                 rstn;
  logic                 csr_query_start;
  logic                 csr_clear;
  logic                 query_en;
  logic                 query_ready;
  logic                 mig_addr_cnt_en;
  logic [ADDR_SIZE-1:0] mig_addr_cnt;
  logic                 mig_addr_cnt_ready;
  logic [IDX_W-1:0]     csr_rd_idx;
  logic [ADDR_SIZE-1:0] csr_rd_data;
  logic [IDX_W:0]       csr_list_cnt;
  logic                 csr_busy;
  logic                 csr_done;
  logic                 csr_timeout;
  logic [15:0]          csr_drop_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  chmu_hotlist_reader #(
    .ADDR_SIZE   (ADDR_SIZE),
    .LIST_SIZE   (LIST_SIZE),
    .IDX_W       (IDX_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .csr_query_start    (csr_query_start),
    .csr_clear          (csr_clear),
    .query_en           (query_en),
    .query_ready        (query_ready),
    .mig_addr_cnt_en    (mig_addr_cnt_en),
    .mig_addr_cnt       (mig_addr_cnt),
    .mig_addr_cnt_ready (mig_addr_cnt_ready),
    .csr_rd_idx         (csr_rd_idx),
    .csr_rd_data        (csr_rd_data),
    .csr_list_cnt       (csr_list_cnt),
    .csr_busy           (csr_busy),
    .csr_done           (csr_done),
    .csr_timeout        (csr_timeout),
    .csr_drop_cnt       (csr_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on total run time.
  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish (observed running, expected finished)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [ADDR_SIZE-1:0] d);
    mig_addr_cnt_en = 1'b1;
    mig_addr_cnt    = d;
    tick();
    mig_addr_cnt_en = 1'b0;
  endtask

  initial begin
    rstn            = 1'b0;
    csr_query_start = 1'b0;
    csr_clear       = 1'b0;
    query_ready     = 1'b0;
    mig_addr_cnt_en = 1'b0;
    mig_addr_cnt    = '0;
    csr_rd_idx      = '0;

    // Reset state
    #1;
    check("rst_query_en", 64'(query_en), 64'd0);
    check("rst_ready", 64'(mig_addr_cnt_ready), 64'd0);
    check("rst_busy", 64'(csr_busy), 64'd0);
    check("rst_done", 64'(csr_done), 64'd0);
    check("rst_list_cnt", 64'(csr_list_cnt), 64'd0);
    check("rst_drop_cnt", 64'(csr_drop_cnt), 64'd0);
    check("rst_rd_data", 64'(csr_rd_data), 64'd0);
    #11 rstn = 1'b1;
    tick();
    check("idle_ready", 64'(mig_addr_cnt_ready), 64'd1);

    // Basic capture: query_ready delayed, query_en held
    csr_query_start = 1'b1;
    tick();
    csr_query_start = 1'b0;
    check("req_query_en", 64'(query_en), 64'd1);
    check("req_busy", 64'(csr_busy), 64'd1);
    check("req_ready", 64'(mig_addr_cnt_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("req_hold_query_en", 64'(query_en), 64'd1);
    end
    query_ready = 1'b1;
    tick();
    query_ready = 1'b0;
    check("col_query_en", 64'(query_en), 64'd0);
    check("col_ready", 64'(mig_addr_cnt_ready), 64'd1);
    check("col_busy", 64'(csr_busy), 64'd1);
    for (int i = 0; i < 32; i++) begin
      mig_addr_cnt_en = 1'b1;
      mig_addr_cnt    = 33'h100 + 33'(i);
      tick();
      if (i == 30) begin
        check("cnt31_list_cnt", 64'(csr_list_cnt), 64'd31);
        check("cnt31_done", 64'(csr_done), 64'd0);
      end
    end
    mig_addr_cnt_en = 1'b0;
    check("full_done", 64'(csr_done), 64'd1);
    check("full_list_cnt", 64'(csr_list_cnt), 64'd32);
    check("full_timeout", 64'(csr_timeout), 64'd0);
    check("full_busy", 64'(csr_busy), 64'd0);
    csr_rd_idx = 5'd5;
    tick();
    check("rd_idx5", 64'(csr_rd_data), 64'h105);
    csr_rd_idx = 5'd31;
    tick();
    check("rd_idx31", 64'(csr_rd_data), 64'h11F);

    // Overflow drop in DONE
    for (int i = 0; i < 3; i++) begin
      send_beat(33'h1DEAD);
      check("drop_ready", 64'(mig_addr_cnt_ready), 64'd1);
    end
    check("drop_cnt3", 64'(csr_drop_cnt), 64'd3);
    csr_rd_idx = 5'd0;
    tick();
    check("drop_rd_idx0", 64'(csr_rd_data), 64'h100);
    check("drop_list_cnt", 64'(csr_list_cnt), 64'd32);

    // Back-to-back query; guards in REQ and COLLECT
    csr_query_start = 1'b1;
    tick();
    csr_query_start = 1'b0;
    check("b2b_list_cnt", 64'(csr_list_cnt), 64'd0);
    check("b2b_done", 64'(csr_done), 64'd0);
    csr_rd_idx = 5'd5;
    csr_clear = 1'b1;
    csr_query_start = 1'b1;
    tick();
    csr_clear = 1'b0;
    csr_query_start = 1'b0;
    check("guard_req_query_en", 64'(query_en), 64'd1);
    check("guard_req_busy", 64'(csr_busy), 64'd1);
    check("b2b_old_rd_idx5", 64'(csr_rd_data), 64'd0);
    query_ready = 1'b1;
    tick();
    query_ready = 1'b0;
    check("b2b_col_query_en", 64'(query_en), 64'd0);
    csr_clear = 1'b1;
    csr_query_start = 1'b1;
    tick();
    csr_clear = 1'b0;
    csr_query_start = 1'b0;
    check("guard_col_busy", 64'(csr_busy), 64'd1);
    check("guard_col_query_en", 64'(query_en), 64'd0);
    check("guard_col_ready", 64'(mig_addr_cnt_ready), 64'd1);

    // Timeout after 7 beats
    for (int i = 0; i < 7; i++) begin
      send_beat(33'h200 + 33'(i));
    end
    check("to_list_cnt7", 64'(csr_list_cnt), 64'd7);
    for (int i = 0; i < 15; i++) tick();
    check("to_not_yet_done", 64'(csr_done), 64'd0);
    check("to_not_yet_busy", 64'(csr_busy), 64'd1);
    tick();
    check("to_done", 64'(csr_done), 64'd1);
    check("to_timeout", 64'(csr_timeout), 64'd1);
    check("to_list_cnt", 64'(csr_list_cnt), 64'd7);
    check("to_busy", 64'(csr_busy), 64'd0);
    csr_rd_idx = 5'd7;
    tick();
    check("to_rd_idx7", 64'(csr_rd_data), 64'd0);
    csr_rd_idx = 5'd6;
    tick();
    check("to_rd_idx6", 64'(csr_rd_data), 64'h206);
    csr_rd_idx = 5'd0;
    tick();
    check("b2b_rd_idx0", 64'(csr_rd_data), 64'h200);

    // Clear and start together in DONE: clear wins
    csr_clear = 1'b1;
    csr_query_start = 1'b1;
    tick();
    csr_clear = 1'b0;
    csr_query_start = 1'b0;
    check("clr_done", 64'(csr_done), 64'd0);
    check("clr_timeout", 64'(csr_timeout), 64'd0);
    check("clr_list_cnt", 64'(csr_list_cnt), 64'd0);
    check("clr_drop_cnt", 64'(csr_drop_cnt), 64'd0);
    check("clr_busy", 64'(csr_busy), 64'd0);
    check("clr_query_en", 64'(query_en), 64'd0);
    tick();
    check("clr_rd_masked", 64'(csr_rd_data), 64'd0);

    // Stale beats in IDLE
    send_beat(33'h1);
    send_beat(33'h2);
    check("idle_drop_cnt", 64'(csr_drop_cnt), 64'd2);
    check("idle_list_cnt", 64'(csr_list_cnt), 64'd0);

    // Async reset mid-COLLECT at the 10th beat
    csr_query_start = 1'b1;
    tick();
    csr_query_start = 1'b0;
    query_ready = 1'b1;
    tick();
    query_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      send_beat(33'h300 + 33'(i));
    end
    check("pre_rst_list_cnt", 64'(csr_list_cnt), 64'd9);
    check("pre_rst_rd_data", 64'(csr_rd_data), 64'h300);
    @(negedge clk);
    mig_addr_cnt_en = 1'b1;
    mig_addr_cnt    = 33'h309;
    rstn            = 1'b0;
    #1;
    check("arst_list_cnt", 64'(csr_list_cnt), 64'd0);
    check("arst_busy", 64'(csr_busy), 64'd0);
    check("arst_ready", 64'(mig_addr_cnt_ready), 64'd0);
    check("arst_rd_data", 64'(csr_rd_data), 64'd0);
    check("arst_drop_cnt", 64'(csr_drop_cnt), 64'd0);
    @(negedge clk);
    mig_addr_cnt_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("post_rst_ready", 64'(mig_addr_cnt_ready), 64'd1);
    check("post_rst_busy", 64'(csr_busy), 64'd0);

    // New query after reset release
    csr_query_start = 1'b1;
    tick();
    csr_query_start = 1'b0;
    check("post_req_query_en", 64'(query_en), 64'd1);
    query_ready = 1'b1;
    tick();
    query_ready = 1'b0;
    send_beat(33'h400);
    send_beat(33'h1_0000_0401);
    csr_rd_idx = 5'd1;
    tick();
    check("post_list_cnt", 64'(csr_list_cnt), 64'd2);
    check("post_rd_idx1", 64'(csr_rd_data), 64'h1_0000_0401);
    check("post_busy", 64'(csr_busy), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
